fft_frame_ctrl: RTL and testbench

- Frame sequencer for the streaming 22SDF FFT core.
- On a start request, reads one N-sample complex frame from sample RAM and drives the core's enable_in/in_re/in_im for exactly N contiguous cycles.
- Collects the N results from enable_out/out_re/out_im and tags each with its bin index.
- Signals frame completion. Supports one queued start.

---
 rtl/fft_frame_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming 22SDF FFT core: feeds one N-sample frame from sample RAM and collects indexed results.
// Optional drain watchdog is compiled in with `define FFT_WDOG_EN.
module fft_frame_ctrl #(
    parameter int N           = 64,
    parameter int LOG2N       = 6,
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 13,
    parameter int FRAME_GAP   = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          frame_cnt,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [2*WIDTH-1:0]   mem_rd_data,
    output logic                 fft_enable_in,
    output logic [WIDTH-1:0]     fft_in_re,
    output logic [WIDTH-1:0]     fft_in_im,
    input  logic                 fft_enable_out,
    input  logic [WIDTH-1:0]     fft_out_re,
    input  logic [WIDTH-1:0]     fft_out_im,
    output logic                 res_valid,
    output logic [LOG2N-1:0]     res_idx,
    output logic [WIDTH-1:0]     res_re,
    output logic [WIDTH-1:0]     res_im
);

    localparam logic [LOG2N-1:0] RD_LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N:0]   RES_FULL = (LOG2N + 1)'(N);
    localparam logic [3:0]       GAP_LAST = 4'(FRAME_GAP - 1);

    // Elaboration-time parameter sanity; never reaches hardware.
    if (N != (1 << LOG2N) || FRAME_GAP < 0 || FRAME_GAP > 15 || WDOG_CYCLES < 2 || ADDR_W <= LOG2N) begin : g_param_check
        $error("fft_frame_ctrl: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE,
        S_GAP
    } state_t;

    state_t                state_reg, state_next;
    logic                  launch;
    logic                  wdog_expire;
    logic                  collecting;
    logic                  accept;

    logic [ADDR_W-1:0]     base_reg;
    logic [ADDR_W-1:0]     pend_addr_reg;
    logic                  pend_reg;
    logic [LOG2N-1:0]      rd_cnt_reg;
    logic [LOG2N:0]        res_cnt_reg;
    logic [3:0]            gap_cnt_reg;
    logic                  rd_valid_reg;
    logic                  error_reg;
    logic [15:0]           frame_cnt_reg;
    logic                  res_valid_reg;
    logic [LOG2N-1:0]      res_idx_reg;
    logic [WIDTH-1:0]      res_re_reg;
    logic [WIDTH-1:0]      res_im_reg;
    logic [WIDTH-1:0]      in_lane [2];

`ifdef FFT_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0]     wdog_cnt_reg;

    // Clears whenever not draining, so it restarts from zero on every DRAIN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_reg <= '0;
        end else if (state_reg != S_DRAIN) begin
            wdog_cnt_reg <= '0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        launch      = 1'b0;
        wdog_expire = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start || pend_reg) begin
                    state_next = S_FEED;
                    launch     = 1'b1;
                end
            end
            S_FEED: begin
                if (rd_cnt_reg == RD_LAST) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_cnt_reg == RES_FULL) begin
                    state_next = S_DONE;
                end
`ifdef FFT_WDOG_EN
                else if (wdog_cnt_reg == WDOG_LAST) begin
                    state_next  = S_IDLE;
                    wdog_expire = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_next = (FRAME_GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign collecting = (state_reg == S_FEED) || (state_reg == S_DRAIN);
    assign accept     = collecting && fft_enable_out && (res_cnt_reg != RES_FULL);

    // A fresh start in IDLE takes priority over (and discards) a queued one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg      <= '0;
            pend_addr_reg <= '0;
            pend_reg      <= 1'b0;
        end else begin
            if (launch) begin
                base_reg <= start ? base_addr : pend_addr_reg;
            end
            if (wdog_expire) begin
                pend_reg <= 1'b0;
            end else if (start && state_reg != S_IDLE) begin
                pend_reg      <= 1'b1;
                pend_addr_reg <= base_addr;
            end else if (state_reg == S_IDLE) begin
                pend_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_reg   <= '0;
            gap_cnt_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (launch) begin
                rd_cnt_reg <= '0;
            end else if (state_reg == S_FEED) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            gap_cnt_reg  <= (state_reg == S_GAP) ? gap_cnt_reg + 1'b1 : 4'd0;
            rd_valid_reg <= mem_rd_en;
        end
    end

    // Result capture: index holds across enable_out gaps and saturates at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_reg   <= '0;
            res_valid_reg <= 1'b0;
            res_idx_reg   <= '0;
            res_re_reg    <= '0;
            res_im_reg    <= '0;
            error_reg     <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            res_valid_reg <= accept;
            if (launch) begin
                res_cnt_reg <= '0;
            end else if (accept) begin
                res_cnt_reg <= res_cnt_reg + 1'b1;
            end
            if (accept) begin
                res_idx_reg <= res_cnt_reg[LOG2N-1:0];
                res_re_reg  <= fft_out_re;
                res_im_reg  <= fft_out_im;
            end
            if ((fft_enable_out && !collecting) || wdog_expire) begin
                error_reg <= 1'b1;
            end
            if (state_reg == S_DONE) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    // RAM word is {re, im}; lanes are forced to zero outside the enable_in burst.
    for (genvar gi = 0; gi < 2; gi++) begin : g_in_lane
        assign in_lane[gi] = rd_valid_reg ? mem_rd_data[gi*WIDTH +: WIDTH] : '0;
    end

    assign busy          = (state_reg != S_IDLE);
    assign done          = (state_reg == S_DONE);
    assign error         = error_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign mem_rd_en     = (state_reg == S_FEED);
    assign mem_addr      = (state_reg == S_FEED) ? base_reg + ADDR_W'(rd_cnt_reg) : '0;
    assign fft_enable_in = rd_valid_reg;
    assign fft_in_re     = in_lane[1];
    assign fft_in_im     = in_lane[0];
    assign res_valid     = res_valid_reg;
    assign res_idx       = res_idx_reg;
    assign res_re        = res_re_reg;
    assign res_im        = res_im_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: RAM model, echoing FFT core stub, per-frame read/result expectations.
// Watchdog section follows `define FFT_WDOG_EN.
module tb_fft_frame_ctrl;

    localparam int N      = 64;
    localparam int LOG2N  = 6;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 13;
    localparam int LAT    = 70;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic                busy;
    logic                done;
    logic                error;
    logic [15:0]         frame_cnt;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [2*WIDTH-1:0]  mem_rd_data;
    logic                fft_enable_in;
    logic [WIDTH-1:0]    fft_in_re;
    logic [WIDTH-1:0]    fft_in_im;
    logic                fft_enable_out;
    logic [WIDTH-1:0]    fft_out_re;
    logic [WIDTH-1:0]    fft_out_im;
    logic                res_valid;
    logic [LOG2N-1:0]    res_idx;
    logic [WIDTH-1:0]    res_re;
    logic [WIDTH-1:0]    res_im;

    fft_frame_ctrl #(
        .N(N), .LOG2N(LOG2N), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
        .FRAME_GAP(2), .WDOG_CYCLES(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .frame_cnt(frame_cnt),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .fft_enable_in(fft_enable_in), .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
        .fft_enable_out(fft_enable_out), .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
        .res_valid(res_valid), .res_idx(res_idx), .res_re(res_re), .res_im(res_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0]     rd_exp_q [$];
    logic [LOG2N+31:0]     res_exp_q [$];
    logic [31:0]           in_q [$];
    int                    in_t [$];

    int cyc = 0;
    int emitted = 0;
    int emit_limit = 1 << 30;
    int hold_left = 0;
    int done_seen = 0;
    int last_res_cyc = 0;
    int in_run = 0;
    bit spur = 1'b0;
    bit gap_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
        logic [15:0] w;
        w = {3'b000, a};
        return {w * 16'd3 + 16'h0101, ~w ^ 16'h5a00};
    endfunction

    task automatic expect_frame(input int base, input int nres);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < N; k++) begin
            a = ADDR_W'(base + k);
            rd_exp_q.push_back(a);
            if (k < nres) res_exp_q.push_back({LOG2N'(k), ram_word(a)});
        end
    endtask

    // One clock: check DUT outputs at the falling edge, then update RAM data and core stub.
    task automatic tick();
        logic [LOG2N+31:0] e;
        logic [31:0]       d;
        @(negedge clk);
        cyc++;
        if (mem_rd_en) begin
            if (rd_exp_q.size() == 0) chk("rd_unexpected", 32'(mem_rd_en), 32'(0));
            else chk("rd_addr", 32'(mem_addr), 32'(rd_exp_q.pop_front()));
        end
        if (res_valid) begin
            if (res_exp_q.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'(0));
            end else begin
                e = res_exp_q.pop_front();
                chk("res_idx", 32'(res_idx), 32'(e[LOG2N+31:32]));
                chk("res_data", {res_re, res_im}, e[31:0]);
            end
            last_res_cyc = cyc;
        end
        if (done) begin
            done_seen++;
            chk("done_latency", 32'(cyc - last_res_cyc), 32'(1));
        end
        if (fft_enable_in) begin
            in_q.push_back({fft_in_re, fft_in_im});
            in_t.push_back(cyc);
            in_run++;
        end else begin
            chk("in_idle_zero", {fft_in_re, fft_in_im}, 32'(0));
            if (in_run > 0) begin
                chk("in_burst_len", 32'(in_run), 32'(N));
                in_run = 0;
            end
        end
        mem_rd_data    = mem_rd_en ? ram_word(mem_addr) : $urandom();
        fft_enable_out = 1'b0;
        fft_out_re     = 16'($urandom());
        fft_out_im     = 16'($urandom());
        if (spur) begin
            fft_enable_out = 1'b1;
        end else if (hold_left > 0) begin
            hold_left--;
        end else if (in_q.size() > 0 && cyc >= in_t[0] + LAT && emitted < emit_limit) begin
            d = in_q.pop_front();
            void'(in_t.pop_front());
            fft_enable_out = 1'b1;
            {fft_out_re, fft_out_im} = d;
            emitted++;
            if (gap_mode && emitted == 21) hold_left = 5;
        end
    endtask

    task automatic pulse_start(input int base);
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = ADDR_W'($urandom());
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        chk("done_wait", 32'(done), 32'(1));
    endtask

    initial begin
        int k;
        int done_before;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; mem_rd_data = '0;
        fft_enable_out = 1'b0; fft_out_re = '0; fft_out_im = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("rst_rd_en", 32'(mem_rd_en), 32'(0));
        chk("rst_en_in", 32'(fft_enable_in), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_idx", 32'(res_idx), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single frame from address 0, with start latency checks
        expect_frame(0, N);
        pulse_start(0);
        chk("rd_latency", 32'(mem_rd_en), 32'(1));
        chk("busy_feed", 32'(busy), 32'(1));
        chk("en_in_lat1", 32'(fft_enable_in), 32'(0));
        tick();
        chk("en_in_lat2", 32'(fft_enable_in), 32'(1));
        wait_done();
        chk("frame_cnt_at_done", 32'(frame_cnt), 32'(0));
        tick();
        chk("frame_cnt1", 32'(frame_cnt), 32'(1));
        chk("done_one_cycle", 32'(done), 32'(0));

        // Address wrap 8191 -> 0
        repeat (4) tick();
        expect_frame(8160, N);
        pulse_start(8160);
        wait_done();
        tick();
        chk("frame_cnt2", 32'(frame_cnt), 32'(2));

        // Queued start, overwritten by a later start before launch
        repeat (4) tick();
        expect_frame(1024, N);
        expect_frame(512, N);
        pulse_start(1024);
        repeat (9) tick();
        pulse_start(128);
        repeat (20) tick();
        pulse_start(512);
        wait_done();
        k = 0;
        do begin
            tick();
            k++;
            if (k == 1) chk("frame_cnt3", 32'(frame_cnt), 32'(3));
            if (k == 3) chk("pend_idle_cycle", 32'(busy), 32'(0));
        end while (mem_rd_en !== 1'b1 && k < 20);
        chk("pend_launch_lat", 32'(k), 32'(4));
        wait_done();
        tick();
        chk("frame_cnt4", 32'(frame_cnt), 32'(4));
        chk("rd_q_empty", 32'(rd_exp_q.size()), 32'(0));
        chk("res_q_empty", 32'(res_exp_q.size()), 32'(0));
        chk("done_count", 32'(done_seen), 32'(4));

        // Gapped enable_out after result 20
        repeat (4) tick();
        emitted = 0;
        gap_mode = 1'b1;
        expect_frame(300, N);
        pulse_start(300);
        wait_done();
        gap_mode = 1'b0;
        tick();
        chk("frame_cnt5", 32'(frame_cnt), 32'(5));
        chk("gap_res_q_empty", 32'(res_exp_q.size()), 32'(0));
        chk("no_error_yet", 32'(error), 32'(0));

        // Spurious enable_out while idle: sticky error, no result
        repeat (4) tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        chk("spur_error", 32'(error), 32'(1));
        chk("spur_busy", 32'(busy), 32'(0));
        repeat (10) tick();
        chk("error_sticky", 32'(error), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_error", 32'(error), 32'(0));
        chk("async_rst_frame_cnt", 32'(frame_cnt), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame with a queued start
        expect_frame(2000, N);
        pulse_start(2000);
        repeat (5) tick();
        pulse_start(3000);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_rd_en", 32'(mem_rd_en), 32'(0));
        chk("midrst_en_in", 32'(fft_enable_in), 32'(0));
        rd_exp_q.delete();
        res_exp_q.delete();
        in_q.delete();
        in_t.delete();
        in_run = 0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("pend_lost", 32'(busy), 32'(0));
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'(0));

        // Core stalls after 10 results
        done_before = done_seen;
        emitted = 0;
        emit_limit = 10;
        expect_frame(4000, 10);
        pulse_start(4000);
        k = 0;
`ifdef FFT_WDOG_EN
        while (error !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        chk("wdog_cycle", 32'(k), 32'(N + 1024));
        chk("wdog_busy", 32'(busy), 32'(0));
        chk("wdog_error", 32'(error), 32'(1));
`else
        repeat (1500) tick();
        chk("nowdog_busy", 32'(busy), 32'(1));
        chk("nowdog_error", 32'(error), 32'(0));
`endif
        repeat (5) tick();
        chk("stall_no_done", 32'(done_seen), 32'(done_before));
        chk("stall_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("stall_res_q_empty", 32'(res_exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
